bcd_stopwatch_ctrl: RTL and testbench
=====================================

Name: bcd_stopwatch_ctrl

Overview:
- Sequencing controller for a chain of cascaded decade (mod-10) counter digits that form a multi-digit BCD stopwatch.
- An internal prescaler generates the count tick.
- A small FSM (IDLE/RUN/PAUSE) handles start, stop, clear and lap commands.
- Drives a live count and a lap-freezable display value toward the display/segment logic.

Parameters:
- DIGITS, 4: number of cascaded BCD digits; must be >= 1.
- PRESCALE, 10: clk cycles per count tick; must be >= 2.
- PW, $clog2(PRESCALE): prescaler width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle command: begin or resume counting.
- stop  input  1  one-cycle command: pause counting.
- clear  input  1  one-cycle command: zero everything and go to IDLE.
- lap  input  1  one-cycle command: toggle display freeze.
- count  output  4*DIGITS  live BCD value; digit 0 = bits [3:0] = least significant.
- disp  output  4*DIGITS  equals count, or the frozen lap value while lap_active=1.
- tick  output  1  one-cycle pulse when the digit chain advances.
- running  output  1  high in RUN.
- lap_active  output  1  display frozen.
- overflow  output  1  sticky; all-9s wrapped to all-0s.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: count=0, disp=0, lap register=0, prescaler=0, tick=0, running=0, lap_active=0, overflow=0, state=IDLE.
- Reset mid-count takes effect immediately and asynchronously.
- Command priority when several are asserted in the same cycle: clear > stop > start. lap is evaluated independently of the others, except that clear overrides lap.
- FSM states:
  - IDLE: start -> RUN. stop and lap are ignored.
  - RUN: stop -> PAUSE. clear -> IDLE.
  - PAUSE: start -> RUN. clear -> IDLE.
  - start while in RUN has no effect. stop while in PAUSE has no effect.
- clear, from any state, in the next cycle: count=0, prescaler=0, lap_active=0, overflow=0, state=IDLE.
- Prescaler:
  - Counts only in RUN: 0..PRESCALE-1, then wraps to 0.
  - Holds its value in PAUSE, so a resume continues the partial period.
  - Is 0 in IDLE.
- tick:
  - Registered; high for exactly one cycle.
  - Asserted in the cycle after the prescaler reaches PRESCALE-1 in RUN.
  - count updates on the same edge tick rises, so tick=1 coincides with the new count.
  - First tick arrives PRESCALE cycles after the start edge.
- If stop is asserted in the cycle the prescaler is at PRESCALE-1, stop wins: no tick, and the prescaler holds at PRESCALE-1.
- Digit chain, on each advance:
  - Digit 0 increments.
  - Digit k increments only when digits 0..k-1 are all 9. Digit values 9 -> 0 wrap.
  - Digits never leave the range 0..9.
- Full-scale wrap: when all digits are 9 and an advance occurs, count -> 0 and overflow is set to 1. overflow stays set until clear or reset. Counting continues.
- Lap, accepted in RUN or PAUSE only:
  - If lap_active=0: latch the current count register value (before any same-edge increment) and set lap_active=1.
  - If lap_active=1: clear lap_active.
- disp = lap_active ? lap register : count (combinational mux).
- Pausing does not affect lap_active.
- running = (state == RUN); registered state decode.

Decomposition:
- Shared package bcd_pkg:
  - BCD_MAX = 4'd9.
  - typedef bcd_digit_t (4-bit).
  - state enum {IDLE, RUN, PAUSE}.
- Sub-module bcd_digit_cell, instantiated DIGITS times in a generate loop:
  - Inputs: clk, reset, clr, en.
  - Outputs: 4-bit q (mod-10 up counter), carry_out = en & (q == 9).
  - Chained: en of digit k = carry_out of digit k-1; en of digit 0 = advance strobe.
- Top level holds the FSM, prescaler, lap register and overflow flag.

Test Plan (DIGITS=2, PRESCALE=3):
- Reset asserted mid-run with count=8'h37 -> all outputs 0 asynchronously, state IDLE; no ticks while IDLE.
- start, then 30 cycles -> tick every 3 cycles; count reaches 8'h10 after the 10th tick; the 9->0 carry into digit 1 occurs exactly at the tick following count=8'h09.
- Run to 8'h99 and one more tick -> count=8'h00, overflow=1; overflow stays 1 through later ticks; clear -> overflow=0, count=0.
- start, stop one cycle after the first prescaler increment, wait 20 cycles, then start -> no ticks during pause; next tick arrives 1 cycle after the resume edge.
- lap at count=8'h25 -> disp=8'h25 while count keeps advancing to 8'h28; lap again -> disp tracks count; lap in IDLE ignored.
- start+stop in same cycle from IDLE -> stays IDLE. clear+lap together -> IDLE, lap_active=0. stop on the cycle the prescaler is at 2 -> no tick, count unchanged.

Source files
------------

// File: rtl/bcd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_pkg                                                    |
// | Purpose  : Shared types and constants for the BCD stopwatch slice.    |
// |            BCD_MAX     - largest legal decimal digit value            |
// |            bcd_digit_t - one 4-bit BCD digit                          |
// |            state_t     - controller states IDLE / RUN / PAUSE         |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package bcd_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_digit_cell                                             |
// | Purpose  : One decade (mod-10) up-counter digit of the cascade.       |
// | Ports    : clk       - system clock, rising edge                      |
// |            reset     - asynchronous active-high reset                 |
// |            clr       - synchronous zero of the digit                  |
// |            en        - advance this digit by one                      |
// |            q         - current digit value, always 0..9               |
// |            carry_out - en while q is 9 (enables the next digit)       |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_digit_cell
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       clr,
   input  logic       en,
   output bcd_digit_t q,
   output logic       carry_out
);

   bcd_digit_t q_d;
   bcd_digit_t q_q;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = (q_q == BCD_MAX) ? 4'd0 : q_q + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q         = q_q;
   assign carry_out = en & (q_q == BCD_MAX);

endmodule : bcd_digit_cell
`default_nettype wire

// File: rtl/bcd_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : bcd_stopwatch_ctrl                                         |
// | Purpose  : Sequencing controller for a cascaded multi-digit BCD       |
// |            stopwatch: prescaler, IDLE/RUN/PAUSE FSM, lap freeze and   |
// |            sticky full-scale overflow flag.                           |
// | Ports    : clk, reset (async, active-high)                            |
// |            start/stop/clear/lap - one-cycle commands                  |
// |            count      - live BCD value, digit 0 in bits [3:0]         |
// |            disp       - count, or the frozen lap value                |
// |            tick       - one-cycle pulse when the digit chain advances |
// |            running    - controller is in RUN                          |
// |            lap_active - display frozen on the lap value               |
// |            overflow   - sticky, all-9s wrapped to all-0s              |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module bcd_stopwatch_ctrl
   import bcd_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 10,
   parameter int PW       = $clog2(PRESCALE)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                stop,
   input  logic                clear,
   input  logic                lap,
   output logic [4*DIGITS-1:0] count,
   output logic [4*DIGITS-1:0] disp,
   output logic                tick,
   output logic                running,
   output logic                lap_active,
   output logic                overflow
);

   localparam logic [PW-1:0] c_presc_last = PW'(PRESCALE - 1);

   state_t              state_q, state_d;
   logic [PW-1:0]       presc_q, presc_d;
   logic                tick_q, tick_d;
   logic                running_q, running_d;
   logic [4*DIGITS-1:0] lap_q, lap_d;
   logic                lap_active_q, lap_active_d;
   logic                overflow_q, overflow_d;

   logic                w_adv;
   logic [DIGITS:0]     w_carry;
   bcd_digit_t          w_digit [DIGITS];

   // The chain advances on the last prescaler slot of RUN; stop or clear
   // in that same cycle suppress the advance.
   assign w_adv      = (state_q == RUN) && !clear && !stop && (presc_q == c_presc_last);
   assign w_carry[0] = w_adv;

   generate
      for (genvar k = 0; k < DIGITS; k++) begin : g_digit
         bcd_digit_cell u_digit (
            .clk       (clk),
            .reset     (reset),
            .clr       (clear),
            .en        (w_carry[k]),
            .q         (w_digit[k]),
            .carry_out (w_carry[k+1])
         );
         assign count[4*k +: 4] = w_digit[k];
      end
   endgenerate

   always_comb begin
      state_d      = state_q;
      presc_d      = presc_q;
      lap_d        = lap_q;
      lap_active_d = lap_active_q;
      overflow_d   = overflow_q | w_carry[DIGITS];

      if (clear) begin
         state_d      = IDLE;
         presc_d      = '0;
         lap_active_d = 1'b0;
         overflow_d   = 1'b0;
      end else begin
         // Lap toggles freeze; the latch takes the pre-increment count.
         if (lap && (state_q != IDLE)) begin
            if (!lap_active_q) begin
               lap_d        = count;
               lap_active_d = 1'b1;
            end else begin
               lap_active_d = 1'b0;
            end
         end

         case (state_q)
            IDLE: begin
               if (start && !stop) state_d = RUN;
            end
            RUN: begin
               // Stop freezes the prescaler so a resume finishes the period.
               if (stop) begin
                  state_d = PAUSE;
               end else begin
                  presc_d = (presc_q == c_presc_last) ? '0 : presc_q + PW'(1);
               end
            end
            PAUSE: begin
               if (start && !stop) state_d = RUN;
            end
            default: begin
               state_d = IDLE;
               presc_d = '0;
            end
         endcase
      end

      tick_d    = w_adv;
      running_d = (state_d == RUN);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         presc_q      <= '0;
         tick_q       <= 1'b0;
         running_q    <= 1'b0;
         lap_q        <= '0;
         lap_active_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         presc_q      <= presc_d;
         tick_q       <= tick_d;
         running_q    <= running_d;
         lap_q        <= lap_d;
         lap_active_q <= lap_active_d;
         overflow_q   <= overflow_d;
      end
   end

   assign disp       = lap_active_q ? lap_q : count;
   assign tick       = tick_q;
   assign running    = running_q;
   assign lap_active = lap_active_q;
   assign overflow   = overflow_q;

endmodule : bcd_stopwatch_ctrl
`default_nettype wire

// File: tb/tb_bcd_stopwatch_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_bcd_stopwatch_ctrl                                      |
// | Purpose  : Self-checking bench for bcd_stopwatch_ctrl (2 digits,      |
// |            prescale 3) with an integer-valued reference model.        |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_bcd_stopwatch_ctrl;

   localparam int DIGITS   = 2;
   localparam int PRESCALE = 3;
   localparam int FULL     = 100;   // 10**DIGITS

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0, stop = 1'b0, clear = 1'b0, lap = 1'b0;
   logic [7:0] count, disp;
   logic       tick, running, lap_active, overflow;

   int checks = 0;
   int errors = 0;

   // Reference model: stopwatch value kept as a plain integer.
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;
   int m_state, m_presc, m_count, m_lapreg;
   bit m_lapact, m_ovf, m_tick;

   bcd_stopwatch_ctrl #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stop       (stop),
      .clear      (clear),
      .lap        (lap),
      .count      (count),
      .disp       (disp),
      .tick       (tick),
      .running    (running),
      .lap_active (lap_active),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) % 10) * 16 + (v % 10));
   endfunction

   task automatic model_reset();
      m_state = M_IDLE; m_presc = 0; m_count = 0; m_lapreg = 0;
      m_lapact = 0; m_ovf = 0; m_tick = 0;
   endtask

   task automatic model_step(input bit st, input bit sp, input bit cl, input bit lp);
      bit adv;
      adv = 0;
      if (cl) begin
         m_state = M_IDLE; m_presc = 0; m_count = 0; m_lapact = 0; m_ovf = 0;
      end else begin
         if (lp && m_state != M_IDLE) begin
            if (!m_lapact) begin
               m_lapreg = m_count;
               m_lapact = 1;
            end else begin
               m_lapact = 0;
            end
         end
         if (m_state == M_IDLE || m_state == M_PAUSE) begin
            if (st && !sp) m_state = M_RUN;
         end else if (sp) begin
            m_state = M_PAUSE;
         end else begin
            m_presc = m_presc + 1;
            if (m_presc == PRESCALE) begin
               m_presc = 0;
               adv = 1;
            end
         end
         if (adv) begin
            if (m_count == FULL - 1) m_ovf = 1;
            m_count = (m_count + 1) % FULL;
         end
      end
      m_tick = adv;
   endtask

   // Drive one cycle of commands, clock it, advance the model, settle.
   task automatic cycle(input bit st, input bit sp, input bit cl, input bit lp);
      start = st; stop = sp; clear = cl; lap = lp;
      @(posedge clk);
      model_step(st, sp, cl, lp);
      #1;
      start = 0; stop = 0; clear = 0; lap = 0;
   endtask

   task automatic test_reset();
      int n;
      bit saw_tick;
      #1;
      checks++;
      if ({count, disp, tick, running, lap_active, overflow} !== 20'd0) begin
         errors++;
         $display("FAIL reset_init: got %h required 0", {count, disp, tick, running, lap_active, overflow});
      end
      #11 reset = 1'b0;
      model_reset();
      cycle(1, 0, 0, 0);
      n = 0;
      while (count !== 8'h37 && n < 400) begin
         cycle(0, 0, 0, 0);
         n++;
      end
      checks++;
      if (count !== 8'h37 || running !== 1'b1) begin
         errors++;
         $display("FAIL reach_37: got count=%h running=%b required 37/1", count, running);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({count, disp, tick, running, lap_active, overflow} !== 20'd0) begin
         errors++;
         $display("FAIL async_reset: got %h required 0", {count, disp, tick, running, lap_active, overflow});
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      saw_tick = 0;
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 0, 0);
         if (tick !== 1'b0 || count !== 8'h00) saw_tick = 1;
      end
      checks++;
      if (saw_tick) begin
         errors++;
         $display("FAIL idle_no_tick: got activity in IDLE required none");
      end
   endtask

   task automatic test_count();
      cycle(1, 0, 0, 0);
      for (int k = 1; k <= 30; k++) begin
         cycle(0, 0, 0, 0);
         checks++;
         if (tick !== ((k % PRESCALE) == 0) || count !== to_bcd(k / PRESCALE)) begin
            errors++;
            $display("FAIL count_k%0d: got tick=%b count=%h required %b/%h",
                     k, tick, count, (k % PRESCALE) == 0, to_bcd(k / PRESCALE));
         end
      end
      checks++;
      if (count !== 8'h10) begin
         errors++;
         $display("FAIL count_10: got %h required 10", count);
      end
   endtask

   task automatic test_overflow();
      int n;
      n = 0;
      while (count !== 8'h99 && n < 400) begin
         cycle(0, 0, 0, 0);
         n++;
      end
      checks++;
      if (count !== 8'h99 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL reach_99: got count=%h ovf=%b required 99/0", count, overflow);
      end
      n = 0;
      do begin
         cycle(0, 0, 0, 0);
         n++;
      end while (tick !== 1'b1 && n < 5);
      checks++;
      if (count !== 8'h00 || overflow !== 1'b1 || tick !== 1'b1) begin
         errors++;
         $display("FAIL wrap: got count=%h ovf=%b tick=%b required 00/1/1", count, overflow, tick);
      end
      for (int i = 0; i < 9; i++) cycle(0, 0, 0, 0);
      checks++;
      if (overflow !== 1'b1 || count !== 8'h03) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b count=%h required 1/03", overflow, count);
      end
      cycle(0, 0, 1, 0);
      checks++;
      if (overflow !== 1'b0 || count !== 8'h00 || running !== 1'b0) begin
         errors++;
         $display("FAIL clear_ovf: got ovf=%b count=%h run=%b required 0/00/0", overflow, count, running);
      end
   endtask

   task automatic test_pause();
      bit saw_tick;
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 0, 0);   // prescaler sits at its last slot here
      checks++;
      if (tick !== 1'b0 || count !== 8'h00 || running !== 1'b0) begin
         errors++;
         $display("FAIL stop_last_slot: got tick=%b count=%h run=%b required 0/00/0", tick, count, running);
      end
      saw_tick = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 0, 0);
         if (tick !== 1'b0 || count !== 8'h00) saw_tick = 1;
      end
      checks++;
      if (saw_tick) begin
         errors++;
         $display("FAIL pause_no_tick: got tick during pause required none");
      end
      cycle(1, 0, 0, 0);
      checks++;
      if (tick !== 1'b0 || running !== 1'b1) begin
         errors++;
         $display("FAIL resume: got tick=%b run=%b required 0/1", tick, running);
      end
      cycle(0, 0, 0, 0);
      checks++;
      if (tick !== 1'b1 || count !== 8'h01) begin
         errors++;
         $display("FAIL resume_tick: got tick=%b count=%h required 1/01", tick, count);
      end
   endtask

   task automatic test_lap();
      int n;
      cycle(0, 0, 1, 0);
      cycle(1, 0, 0, 0);
      n = 0;
      while (count !== 8'h25 && n < 200) begin
         cycle(0, 0, 0, 0);
         n++;
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (lap_active !== 1'b1 || disp !== 8'h25) begin
         errors++;
         $display("FAIL lap_latch: got act=%b disp=%h required 1/25", lap_active, disp);
      end
      n = 0;
      while (count !== 8'h28 && n < 20) begin
         cycle(0, 0, 0, 0);
         n++;
      end
      checks++;
      if (count !== 8'h28 || disp !== 8'h25) begin
         errors++;
         $display("FAIL lap_hold: got count=%h disp=%h required 28/25", count, disp);
      end
      cycle(0, 0, 0, 1);
      checks++;
      if (lap_active !== 1'b0 || disp !== to_bcd(m_count)) begin
         errors++;
         $display("FAIL lap_release: got act=%b disp=%h required 0/%h", lap_active, disp, to_bcd(m_count));
      end
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 1);
      checks++;
      if (lap_active !== 1'b0 || disp !== 8'h00) begin
         errors++;
         $display("FAIL lap_idle: got act=%b disp=%h required 0/00", lap_active, disp);
      end
   endtask

   task automatic test_combos();
      bit saw_tick;
      cycle(1, 1, 0, 0);
      saw_tick = 0;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 0, 0);
         if (tick !== 1'b0 || running !== 1'b0) saw_tick = 1;
      end
      checks++;
      if (saw_tick) begin
         errors++;
         $display("FAIL start_stop_idle: got RUN activity required IDLE");
      end
      cycle(1, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 1);
      cycle(0, 0, 1, 1);
      checks++;
      if (lap_active !== 1'b0 || running !== 1'b0 || count !== 8'h00) begin
         errors++;
         $display("FAIL clear_lap: got act=%b run=%b count=%h required 0/0/00", lap_active, running, count);
      end
   endtask

   task automatic test_random();
      bit st, sp, cl, lp;
      logic [7:0] exp_disp;
      for (int i = 0; i < 3000; i++) begin
         st = ($urandom_range(0, 7) == 0);
         sp = ($urandom_range(0, 15) == 0);
         cl = ($urandom_range(0, 99) == 0);
         lp = ($urandom_range(0, 15) == 0);
         cycle(st, sp, cl, lp);
         exp_disp = m_lapact ? to_bcd(m_lapreg) : to_bcd(m_count);
         checks++;
         if (count !== to_bcd(m_count) || disp !== exp_disp || tick !== m_tick) begin
            errors++;
            $display("FAIL rand_value c%0d: got count=%h disp=%h tick=%b required %h/%h/%b",
                     i, count, disp, tick, to_bcd(m_count), exp_disp, m_tick);
         end
         checks++;
         if (running !== (m_state == M_RUN) || lap_active !== m_lapact || overflow !== m_ovf) begin
            errors++;
            $display("FAIL rand_flags c%0d: got run=%b act=%b ovf=%b required %b/%b/%b",
                     i, running, lap_active, overflow, m_state == M_RUN, m_lapact, m_ovf);
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_count();
      test_overflow();
      test_pause();
      test_lap();
      test_combos();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bcd_stopwatch_ctrl
`default_nettype wire
